// File: rtl/msrh_lsu_pkg.sv
// rtl/msrh_lsu_pkg.sv - shared types for the I-side L2 request arbiter
//
// Purpose: owner/state enums, the tag table entry record and the line
// alignment helper used by msrh_ic_l2_arbiter and msrh_ic_l2_tag_table.
// Ports: none (package).
package msrh_lsu_pkg;

  // Entry address width; the arbiter's PADDR_W must match it.
  localparam int IC_L2_PADDR_W = 56;

  typedef enum logic {
    OWNER_DMD = 1'b0,
    OWNER_PF  = 1'b1
  } ic_l2_owner_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } ic_l2_arb_state_t;

  typedef struct packed {
    logic                     valid;
    ic_l2_owner_t             owner;
    logic [IC_L2_PADDR_W-1:0] paddr;
    logic                     killed;
  } ic_l2_entry_t;

  // Clear the byte-in-line offset bits.
  function automatic logic [IC_L2_PADDR_W-1:0] ic_l2_line_align(
    input logic [IC_L2_PADDR_W-1:0] paddr,
    input int                       off_w
  );
    return paddr & ~((IC_L2_PADDR_W'(1) << off_w) - IC_L2_PADDR_W'(1));
  endfunction

endpackage

// File: rtl/msrh_ic_l2_tag_table.sv
// rtl/msrh_ic_l2_tag_table.sv - in-flight L2 line request table
//
// Purpose: holds one entry per outstanding L2 line request, indexed by tag.
// Ports:
//   i_alloc_*      write a new entry into the lowest free slot
//   o_free_*       lowest free slot (valid + tag)
//   i_match_paddr  line address compared against live prefetch entries
//   o_match_hit    a valid, non-killed PF entry matches and is not being freed
//   i_merge_valid  hand the matched PF entry over to the demand side
//   i_flush_valid  mark every valid PF entry killed
//   i_resp_*       response tag; frees the entry, o_resp_entry is its content
//   o_any_valid    at least one entry in flight
module msrh_ic_l2_tag_table
  import msrh_lsu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_W           = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_alloc_valid,
  input  ic_l2_owner_t             i_alloc_owner,
  input  logic [IC_L2_PADDR_W-1:0] i_alloc_paddr,
  output logic                     o_free_valid,
  output logic [TAG_W-1:0]         o_free_tag,
  input  logic [IC_L2_PADDR_W-1:0] i_match_paddr,
  output logic                     o_match_hit,
  input  logic                     i_merge_valid,
  input  logic                     i_flush_valid,
  input  logic                     i_resp_valid,
  input  logic [TAG_W-1:0]         i_resp_tag,
  output ic_l2_entry_t             o_resp_entry,
  output logic                     o_any_valid
);

  ic_l2_entry_t               r_entries [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] w_resp_hit;
  logic [MAX_OUTSTANDING-1:0] w_match;
  logic [MAX_OUTSTANDING-1:0] w_merge;
  logic [MAX_OUTSTANDING-1:0] w_alloc_sel;

  always_comb begin
    o_free_valid = 1'b0;
    o_free_tag   = '0;
    o_any_valid  = 1'b0;
    o_resp_entry = '0;
    w_resp_hit   = '0;
    w_match      = '0;
    // Walk downwards so the lowest free index is the last one written.
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!r_entries[i].valid) begin
        o_free_valid = 1'b1;
        o_free_tag   = TAG_W'(i);
      end
      if (r_entries[i].valid) o_any_valid = 1'b1;
      w_resp_hit[i] = i_resp_valid && (i_resp_tag == TAG_W'(i));
      if (w_resp_hit[i]) o_resp_entry = r_entries[i];
      // An entry whose response lands this cycle is already gone; merging
      // into it would lose the demand.
      w_match[i] = r_entries[i].valid && (r_entries[i].owner == OWNER_PF) &&
                   !r_entries[i].killed && (r_entries[i].paddr == i_match_paddr) &&
                   !w_resp_hit[i];
    end
  end

  always_comb begin
    w_alloc_sel = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      w_alloc_sel[i] = i_alloc_valid && o_free_valid && (o_free_tag == TAG_W'(i));
    end
  end

  // Duplicate prefetches of one line may coexist; only the lowest takes the merge.
  assign w_merge     = {MAX_OUTSTANDING{i_merge_valid}} &
                       w_match & (~w_match + MAX_OUTSTANDING'(1));
  assign o_match_hit = |w_match;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_entries[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        // Allocation only targets free slots, so a stray response to the same
        // (invalid) slot must not cancel it.
        if (w_alloc_sel[i]) begin
          r_entries[i].valid  <= 1'b1;
          r_entries[i].owner  <= i_alloc_owner;
          r_entries[i].paddr  <= i_alloc_paddr;
          r_entries[i].killed <= 1'b0;
        end else if (w_resp_hit[i]) begin
          r_entries[i] <= '0;
        end else if (w_merge[i]) begin
          r_entries[i].owner <= OWNER_DMD;
        end else if (i_flush_valid && r_entries[i].valid &&
                     (r_entries[i].owner == OWNER_PF)) begin
          r_entries[i].killed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/msrh_ic_l2_arbiter.sv
// rtl/msrh_ic_l2_arbiter.sv - demand/prefetch arbiter for the I-side L2 port
//
// Purpose: arbitrates I-cache demand misses against next-line prefetches onto
// one L2 request channel, tracks in-flight lines by tag, merges demands into
// matching prefetches, and routes responses back to their owner.
// Ports:
//   i_clk, i_reset_n              clock, async active-low reset
//   i_flush_valid                 frontend flush; kills in-flight prefetches
//   i_dmd_* / o_dmd_ready         demand miss request
//   i_pf_*  / o_pf_ready          prefetch request
//   o_l2_req_* / i_l2_req_ready   registered L2 request
//   i_l2_resp_*                   L2 response (tag, data)
//   o_dmd_resp_*, o_pf_resp_*     registered one-cycle fill pulses
//   o_busy                        entries in flight or request pending
module msrh_ic_l2_arbiter
  import msrh_lsu_pkg::*;
#(
  parameter int PADDR_W         = IC_L2_PADDR_W,
  parameter int DATA_W          = 256,
  parameter int TAG_W           = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_flush_valid,
  input  logic               i_dmd_valid,
  output logic               o_dmd_ready,
  input  logic [PADDR_W-1:0] i_dmd_paddr,
  input  logic               i_pf_valid,
  output logic               o_pf_ready,
  input  logic [PADDR_W-1:0] i_pf_paddr,
  output logic               o_l2_req_valid,
  input  logic               i_l2_req_ready,
  output logic [PADDR_W-1:0] o_l2_req_paddr,
  output logic [TAG_W-1:0]   o_l2_req_tag,
  input  logic               i_l2_resp_valid,
  input  logic [TAG_W-1:0]   i_l2_resp_tag,
  input  logic [DATA_W-1:0]  i_l2_resp_data,
  output logic               o_dmd_resp_valid,
  output logic [PADDR_W-1:0] o_dmd_resp_paddr,
  output logic [DATA_W-1:0]  o_dmd_resp_data,
  output logic               o_pf_resp_valid,
  output logic [PADDR_W-1:0] o_pf_resp_paddr,
  output logic [DATA_W-1:0]  o_pf_resp_data,
  output logic               o_busy
);

  localparam int OFF_W    = $clog2(DATA_W / 8);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  ic_l2_arb_state_t    r_state;
  logic [STARVE_W-1:0] r_starve;
  logic [PADDR_W-1:0]  w_dmd_line;
  logic [PADDR_W-1:0]  w_pf_line;
  logic                w_free_valid;
  logic [TAG_W-1:0]    w_free_tag;
  logic                w_match_hit;
  logic                w_any_valid;
  ic_l2_entry_t        w_resp_entry;
  logic                w_grant_ok;
  logic                w_pf_pending;
  logic                w_pf_force;
  logic                w_dmd_merge;
  logic                w_issue;
  logic                w_resp_live;

  assign w_dmd_line = ic_l2_line_align(i_dmd_paddr, OFF_W);
  assign w_pf_line  = ic_l2_line_align(i_pf_paddr, OFF_W);

  // The output register can take a new request when empty or draining now.
  assign w_grant_ok   = ((r_state == IDLE) || i_l2_req_ready) && w_free_valid;
  assign w_pf_pending = i_pf_valid && !i_flush_valid;
  assign w_pf_force   = w_pf_pending && (r_starve == STARVE_W'(STARVE_LIMIT));

  // A starved prefetch that can actually be granted blocks the demand, merge
  // included, so the two readies stay mutually exclusive.
  assign o_dmd_ready = i_dmd_valid && !(w_pf_force && w_grant_ok) &&
                       (w_match_hit || w_grant_ok);
  assign o_pf_ready  = w_pf_pending && w_grant_ok && (w_pf_force || !i_dmd_valid);
  assign w_dmd_merge = o_dmd_ready && w_match_hit;
  assign w_issue     = o_pf_ready || (o_dmd_ready && !w_match_hit);

  msrh_ic_l2_tag_table #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TAG_W           (TAG_W)
  ) u_tag_table (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_alloc_valid (w_issue),
    .i_alloc_owner (o_pf_ready ? OWNER_PF : OWNER_DMD),
    .i_alloc_paddr (o_pf_ready ? w_pf_line : w_dmd_line),
    .o_free_valid  (w_free_valid),
    .o_free_tag    (w_free_tag),
    .i_match_paddr (w_dmd_line),
    .o_match_hit   (w_match_hit),
    .i_merge_valid (w_dmd_merge),
    .i_flush_valid (i_flush_valid),
    .i_resp_valid  (i_l2_resp_valid),
    .i_resp_tag    (i_l2_resp_tag),
    .o_resp_entry  (w_resp_entry),
    .o_any_valid   (w_any_valid)
  );

  assign o_l2_req_valid = (r_state == REQ);
  assign o_busy         = w_any_valid || (r_state == REQ);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= IDLE;
      o_l2_req_paddr <= '0;
      o_l2_req_tag   <= '0;
    end else if (w_issue) begin
      r_state        <= REQ;
      o_l2_req_paddr <= o_pf_ready ? w_pf_line : w_dmd_line;
      o_l2_req_tag   <= w_free_tag;
    end else if (i_l2_req_ready) begin
      r_state <= IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_starve <= '0;
    end else if (o_pf_ready) begin
      r_starve <= '0;
    end else if (i_pf_valid && (r_starve != STARVE_W'(STARVE_LIMIT))) begin
      r_starve <= r_starve + STARVE_W'(1);
    end
  end

  // Killed or unknown-tag responses are swallowed; a PF response racing a
  // flush is dropped even though its kill mark is not yet visible.
  assign w_resp_live = i_l2_resp_valid && w_resp_entry.valid && !w_resp_entry.killed;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dmd_resp_valid <= 1'b0;
      o_dmd_resp_paddr <= '0;
      o_dmd_resp_data  <= '0;
      o_pf_resp_valid  <= 1'b0;
      o_pf_resp_paddr  <= '0;
      o_pf_resp_data   <= '0;
    end else begin
      o_dmd_resp_valid <= w_resp_live && (w_resp_entry.owner == OWNER_DMD);
      o_pf_resp_valid  <= w_resp_live && (w_resp_entry.owner == OWNER_PF) && !i_flush_valid;
      if (w_resp_live && (w_resp_entry.owner == OWNER_DMD)) begin
        o_dmd_resp_paddr <= w_resp_entry.paddr;
        o_dmd_resp_data  <= i_l2_resp_data;
      end
      if (w_resp_live && (w_resp_entry.owner == OWNER_PF)) begin
        o_pf_resp_paddr <= w_resp_entry.paddr;
        o_pf_resp_data  <= i_l2_resp_data;
      end
    end
  end

`ifdef SIMULATION
  always_ff @(posedge i_clk) begin
    if (i_reset_n && i_l2_resp_valid && !w_resp_entry.valid)
      $fatal(1, "msrh_ic_l2_arbiter: response to invalid tag %0d", i_l2_resp_tag);
  end
`endif

endmodule

// File: tb/tb_msrh_ic_l2_arbiter.sv
// tb/tb_msrh_ic_l2_arbiter.sv - self-checking bench for msrh_ic_l2_arbiter
module tb_msrh_ic_l2_arbiter;

  localparam int PW = 56;
  localparam int DW = 256;
  localparam int TW = 4;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_flush_valid;
  logic          i_dmd_valid;
  logic          o_dmd_ready;
  logic [PW-1:0] i_dmd_paddr;
  logic          i_pf_valid;
  logic          o_pf_ready;
  logic [PW-1:0] i_pf_paddr;
  logic          o_l2_req_valid;
  logic          i_l2_req_ready;
  logic [PW-1:0] o_l2_req_paddr;
  logic [TW-1:0] o_l2_req_tag;
  logic          i_l2_resp_valid;
  logic [TW-1:0] i_l2_resp_tag;
  logic [DW-1:0] i_l2_resp_data;
  logic          o_dmd_resp_valid;
  logic [PW-1:0] o_dmd_resp_paddr;
  logic [DW-1:0] o_dmd_resp_data;
  logic          o_pf_resp_valid;
  logic [PW-1:0] o_pf_resp_paddr;
  logic [DW-1:0] o_pf_resp_data;
  logic          o_busy;

  always #5 i_clk = ~i_clk;

  msrh_ic_l2_arbiter dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_flush_valid    (i_flush_valid),
    .i_dmd_valid      (i_dmd_valid),
    .o_dmd_ready      (o_dmd_ready),
    .i_dmd_paddr      (i_dmd_paddr),
    .i_pf_valid       (i_pf_valid),
    .o_pf_ready       (o_pf_ready),
    .i_pf_paddr       (i_pf_paddr),
    .o_l2_req_valid   (o_l2_req_valid),
    .i_l2_req_ready   (i_l2_req_ready),
    .o_l2_req_paddr   (o_l2_req_paddr),
    .o_l2_req_tag     (o_l2_req_tag),
    .i_l2_resp_valid  (i_l2_resp_valid),
    .i_l2_resp_tag    (i_l2_resp_tag),
    .i_l2_resp_data   (i_l2_resp_data),
    .o_dmd_resp_valid (o_dmd_resp_valid),
    .o_dmd_resp_paddr (o_dmd_resp_paddr),
    .o_dmd_resp_data  (o_dmd_resp_data),
    .o_pf_resp_valid  (o_pf_resp_valid),
    .o_pf_resp_paddr  (o_pf_resp_paddr),
    .o_pf_resp_data   (o_pf_resp_data),
    .o_busy           (o_busy)
  );

  typedef struct {
    logic [PW-1:0] paddr;
    logic [TW-1:0] tag;
  } req_t;

  typedef struct {
    logic [PW-1:0] paddr;
    logic [DW-1:0] data;
  } resp_t;

  typedef struct {
    bit            is_pf;
    logic [PW-1:0] paddr;
    logic [PW-1:0] exp_paddr;
    logic [DW-1:0] data;
  } vec_t;

  req_t  exp_req[$];
  resp_t exp_dmd[$];
  resp_t exp_pf[$];
  vec_t  vecs[4];
  int    total = 0;
  int    bad   = 0;

  function automatic void chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  task automatic push_req(input logic [PW-1:0] a, input int t);
    req_t r;
    r.paddr = a;
    r.tag   = TW'(t);
    exp_req.push_back(r);
  endtask

  task automatic push_resp(input bit is_pf, input logic [PW-1:0] a, input logic [DW-1:0] d);
    resp_t r;
    r.paddr = a;
    r.data  = d;
    if (is_pf) exp_pf.push_back(r);
    else exp_dmd.push_back(r);
  endtask

  task automatic respond(input int t, input logic [DW-1:0] d);
    i_l2_resp_valid = 1'b1;
    i_l2_resp_tag   = TW'(t);
    i_l2_resp_data  = d;
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard side: compare accepted requests and fill pulses in order.
  always @(negedge i_clk) begin
    req_t  r;
    resp_t p;
    if (i_reset_n) begin
      if (o_l2_req_valid && i_l2_req_ready) begin
        if (exp_req.size() == 0) chk("unexp_req", DW'(1), DW'(0));
        else begin
          r = exp_req.pop_front();
          chk("req_paddr", DW'(o_l2_req_paddr), DW'(r.paddr));
          chk("req_tag", DW'(o_l2_req_tag), DW'(r.tag));
        end
      end
      if (o_dmd_resp_valid) begin
        if (exp_dmd.size() == 0) chk("unexp_dmd_resp", DW'(1), DW'(0));
        else begin
          p = exp_dmd.pop_front();
          chk("dmd_resp_paddr", DW'(o_dmd_resp_paddr), DW'(p.paddr));
          chk("dmd_resp_data", o_dmd_resp_data, p.data);
        end
      end
      if (o_pf_resp_valid) begin
        if (exp_pf.size() == 0) chk("unexp_pf_resp", DW'(1), DW'(0));
        else begin
          p = exp_pf.pop_front();
          chk("pf_resp_paddr", DW'(o_pf_resp_paddr), DW'(p.paddr));
          chk("pf_resp_data", o_pf_resp_data, p.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [PW-1:0] a [5];
    logic [DW-1:0] d;
    int            order [4];

    vecs[0] = '{is_pf: 1'b0, paddr: 56'h8000_0044, exp_paddr: 56'h8000_0040,
                data: {4{64'h0123_4567_89ab_cdef}}};
    vecs[1] = '{is_pf: 1'b1, paddr: 56'h8000_007f, exp_paddr: 56'h8000_0060,
                data: {4{64'hfeed_beef_cafe_f00d}}};
    vecs[2] = '{is_pf: 1'b0, paddr: 56'hff_ffff_ffff_ffff, exp_paddr: 56'hff_ffff_ffff_ffe0,
                data: {4{64'h5555_aaaa_3333_cccc}}};
    vecs[3] = '{is_pf: 1'b1, paddr: 56'h1234_5678_9abf, exp_paddr: 56'h1234_5678_9aa0,
                data: {4{64'h0f0f_1e1e_2d2d_3c3c}}};

    i_reset_n = 1'b0;
    i_flush_valid = 1'b0;
    i_dmd_valid = 1'b0;
    i_dmd_paddr = '0;
    i_pf_valid = 1'b0;
    i_pf_paddr = '0;
    i_l2_req_ready = 1'b1;
    i_l2_resp_valid = 1'b0;
    i_l2_resp_tag = '0;
    i_l2_resp_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_req_valid", DW'(o_l2_req_valid), DW'(0));
    chk("rst_dmd_ready", DW'(o_dmd_ready), DW'(0));
    chk("rst_pf_ready", DW'(o_pf_ready), DW'(0));
    chk("rst_busy", DW'(o_busy), DW'(0));
    chk("rst_dmd_resp", DW'(o_dmd_resp_valid), DW'(0));
    chk("rst_pf_resp", DW'(o_pf_resp_valid), DW'(0));
    chk("rst_req_paddr", DW'(o_l2_req_paddr), DW'(0));
    i_reset_n = 1'b1;
    cyc();

    // Single transactions from idle, each reusing tag 0.
    for (int v = 0; v < 4; v++) begin
      cyc();
      if (vecs[v].is_pf) begin i_pf_valid = 1'b1; i_pf_paddr = vecs[v].paddr; end
      else begin i_dmd_valid = 1'b1; i_dmd_paddr = vecs[v].paddr; end
      #1;
      chk("vec_grant", DW'(vecs[v].is_pf ? o_pf_ready : o_dmd_ready), DW'(1));
      chk("vec_other", DW'(vecs[v].is_pf ? o_dmd_ready : o_pf_ready), DW'(0));
      push_req(vecs[v].exp_paddr, 0);
      cyc();
      i_dmd_valid = 1'b0;
      i_pf_valid = 1'b0;
      chk("vec_req_valid", DW'(o_l2_req_valid), DW'(1));
      cyc();
      chk("vec_req_done", DW'(o_l2_req_valid), DW'(0));
      respond(0, vecs[v].data);
      push_resp(vecs[v].is_pf, vecs[v].exp_paddr, vecs[v].data);
      cyc();
      i_l2_resp_valid = 1'b0;
      chk("vec_resp_valid", DW'(vecs[v].is_pf ? o_pf_resp_valid : o_dmd_resp_valid), DW'(1));
    end

    // Starvation: both valid every cycle; the 9th cycle (c=8) goes to prefetch.
    for (int c = 0; c < 11; c++) begin
      cyc();
      i_dmd_valid = 1'b1;
      i_dmd_paddr = 56'h9000_0000;
      i_pf_valid  = 1'b1;
      i_pf_paddr  = 56'h9100_0000;
      if (c > 0) begin
        d = DW'(c + 100);
        respond((c - 1) % 2, d);
        if (c - 1 == 8) push_resp(1'b1, 56'h9100_0000, d);
        else push_resp(1'b0, 56'h9000_0000, d);
      end
      #1;
      if (c == 8) begin
        chk("starve_pf_win", DW'(o_pf_ready), DW'(1));
        chk("starve_dmd_lose", DW'(o_dmd_ready), DW'(0));
        push_req(56'h9100_0000, c % 2);
      end else begin
        chk("starve_dmd_win", DW'(o_dmd_ready), DW'(1));
        chk("starve_pf_lose", DW'(o_pf_ready), DW'(0));
        push_req(56'h9000_0000, c % 2);
      end
    end
    cyc();
    i_dmd_valid = 1'b0;
    i_pf_valid = 1'b0;
    respond(0, DW'(111));
    push_resp(1'b0, 56'h9000_0000, DW'(111));
    cyc();
    i_l2_resp_valid = 1'b0;
    cyc();

    // Table full: four outstanding demands, then tag 2 frees and is reused.
    for (int k = 0; k < 5; k++) a[k] = 56'hA000_0000 + PW'(k * 256);
    for (int k = 0; k < 4; k++) begin
      cyc();
      i_dmd_valid = 1'b1;
      i_dmd_paddr = a[k];
      #1;
      chk("fill_grant", DW'(o_dmd_ready), DW'(1));
      push_req(a[k], k);
    end
    cyc();
    i_dmd_paddr = a[4];
    #1;
    chk("full_block", DW'(o_dmd_ready), DW'(0));
    cyc();
    respond(2, DW'(202));
    push_resp(1'b0, a[2], DW'(202));
    #1;
    chk("full_block_resp_cycle", DW'(o_dmd_ready), DW'(0));
    cyc();
    i_l2_resp_valid = 1'b0;
    #1;
    chk("refill_grant", DW'(o_dmd_ready), DW'(1));
    push_req(a[4], 2);
    cyc();
    i_dmd_valid = 1'b0;
    order = '{0, 1, 3, 2};
    for (int k = 0; k < 4; k++) begin
      cyc();
      respond(order[k], DW'(300 + k));
      push_resp(1'b0, (order[k] == 2) ? a[4] : a[order[k]], DW'(300 + k));
    end
    cyc();
    i_l2_resp_valid = 1'b0;
    cyc();

    // Stall: ready low for 5 cycles, then back-to-back grant on accept.
    cyc();
    i_dmd_valid = 1'b1;
    i_dmd_paddr = 56'hB000_0020;
    #1;
    chk("stall_grant", DW'(o_dmd_ready), DW'(1));
    push_req(56'hB000_0020, 0);
    cyc();
    i_l2_req_ready = 1'b0;
    i_dmd_paddr = 56'hB000_1000;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("stall_valid", DW'(o_l2_req_valid), DW'(1));
      chk("stall_paddr", DW'(o_l2_req_paddr), DW'(56'hB000_0020));
      chk("stall_tag", DW'(o_l2_req_tag), DW'(0));
      chk("stall_no_grant", DW'(o_dmd_ready), DW'(0));
      cyc();
    end
    i_l2_req_ready = 1'b1;
    #1;
    chk("b2b_grant", DW'(o_dmd_ready), DW'(1));
    push_req(56'hB000_1000, 1);
    cyc();
    i_dmd_valid = 1'b0;
    cyc();
    respond(0, DW'(400));
    push_resp(1'b0, 56'hB000_0020, DW'(400));
    cyc();
    respond(1, DW'(401));
    push_resp(1'b0, 56'hB000_1000, DW'(401));
    cyc();
    i_l2_resp_valid = 1'b0;
    cyc();

    // Merge: demand to an in-flight prefetch line takes it over.
    cyc();
    i_pf_valid = 1'b1;
    i_pf_paddr = 56'h8000_1000;
    #1;
    chk("merge_pf_grant", DW'(o_pf_ready), DW'(1));
    push_req(56'h8000_1000, 0);
    cyc();
    i_pf_valid = 1'b0;
    i_dmd_valid = 1'b1;
    i_dmd_paddr = 56'h8000_1010;
    #1;
    chk("merge_dmd_ready", DW'(o_dmd_ready), DW'(1));
    chk("merge_pf_ready", DW'(o_pf_ready), DW'(0));
    cyc();
    i_dmd_valid = 1'b0;
    chk("merge_no_req", DW'(o_l2_req_valid), DW'(0));
    respond(0, DW'(500));
    push_resp(1'b0, 56'h8000_1000, DW'(500));
    cyc();
    i_l2_resp_valid = 1'b0;
    chk("merge_dmd_resp", DW'(o_dmd_resp_valid), DW'(1));
    chk("merge_no_pf_resp", DW'(o_pf_resp_valid), DW'(0));
    cyc();

    // Flush: in-flight prefetch response is dropped and its entry reused.
    cyc();
    i_pf_valid = 1'b1;
    i_pf_paddr = 56'h8000_2000;
    #1;
    chk("flush_pf_grant", DW'(o_pf_ready), DW'(1));
    push_req(56'h8000_2000, 0);
    cyc();
    i_flush_valid = 1'b1;
    i_pf_paddr = 56'h8000_2020;
    #1;
    chk("flush_pf_block", DW'(o_pf_ready), DW'(0));
    cyc();
    i_flush_valid = 1'b0;
    i_pf_valid = 1'b0;
    respond(0, DW'(600));
    cyc();
    i_l2_resp_valid = 1'b0;
    chk("flush_pf_dropped", DW'(o_pf_resp_valid), DW'(0));
    chk("flush_idle", DW'(o_busy), DW'(0));
    i_dmd_valid = 1'b1;
    i_dmd_paddr = 56'h8000_3000;
    #1;
    chk("flush_reuse_grant", DW'(o_dmd_ready), DW'(1));
    push_req(56'h8000_3000, 0);
    cyc();
    i_dmd_valid = 1'b0;
    cyc();
    respond(0, DW'(601));
    push_resp(1'b0, 56'h8000_3000, DW'(601));
    cyc();
    i_l2_resp_valid = 1'b0;
    cyc();
    cyc();

    chk("left_req", DW'(exp_req.size()), DW'(0));
    chk("left_dmd", DW'(exp_dmd.size()), DW'(0));
    chk("left_pf", DW'(exp_pf.size()), DW'(0));
    chk("end_busy", DW'(o_busy), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
